// File: rtl/rv32i_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute stream bundle.
// slave: decode stage view; master: the driving/consuming side.
interface rv32i_decode_stage_if #(
  parameter int PC_WIDTH = 32
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [PC_WIDTH-1:0] in_pc;
  logic [31:0]         in_inst;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [6:0]          out_opcode;
  logic [4:0]          out_rd;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [2:0]          out_funct3;
  logic [6:0]          out_funct7;
  logic [31:0]         out_imm;
  logic                out_illegal;

  modport slave (
    input  flush, in_valid, in_pc, in_inst,
    input  out_ready,
    output in_ready, out_valid, out_pc,
    output out_opcode, out_rd, out_rs1,
    output out_rs2, out_funct3, out_funct7,
    output out_imm, out_illegal
  );

  modport master (
    output flush, in_valid, in_pc, in_inst,
    output out_ready,
    input  in_ready, out_valid, out_pc,
    input  out_opcode, out_rd, out_rs1,
    input  out_rs2, out_funct3, out_funct7,
    input  out_imm, out_illegal
  );
endinterface

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: field split, immediate, illegal flag.
// Ports: clk, rst (async high), bus (slave stream bundle).
module rv32i_decode_stage #(
  parameter int PC_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  rv32i_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [31:0]         imm;
    logic                illegal;
  } dec_t;

  localparam logic [6:0] OP_OP  = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_AUI = 7'h17;
  localparam logic [6:0] OP_JAL = 7'h6f;
  localparam logic [6:0] OP_JLR = 7'h67;
  localparam logic [6:0] OP_BR  = 7'h63;
  localparam logic [6:0] OP_SYS = 7'h73;
  localparam logic [6:0] OP_FEN = 7'h0f;

  logic [31:0] i;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        ill;
  dec_t        dec;

  dec_t out_q;
  dec_t skid_q;
  logic out_v;
  logic skid_v;
  logic acc;
  logic free;

  assign i  = bus.in_inst;
  assign op = i[6:0];
  assign f3 = i[14:12];
  assign f7 = i[31:25];

  always_comb begin
    ill = 1'b0;
    unique case (op)
      OP_OP:
        ill = !(f7 == 7'h00 ||
                (f7 == 7'h20 &&
                 (f3 == 3'd0 || f3 == 3'd5)));
      OP_IMM:
        ill = (f3 == 3'd1 && f7 != 7'h00) ||
              (f3 == 3'd5 && f7 != 7'h00 &&
               f7 != 7'h20);
      OP_LD:
        ill = f3 == 3'd3 || f3 == 3'd6 ||
              f3 == 3'd7;
      OP_ST:
        ill = f3 > 3'd2;
      OP_BR:
        ill = f3 == 3'd2 || f3 == 3'd3;
      OP_JLR:
        ill = f3 != 3'd0;
      OP_SYS:
        ill = f3 == 3'd4 ||
              (f3 == 3'd0 &&
               i != 32'h0000_0073 &&
               i != 32'h0010_0073);
      OP_LUI, OP_AUI, OP_JAL, OP_FEN:
        ill = 1'b0;
      default:
        ill = 1'b1;
    endcase
    if (i[1:0] != 2'b11) ill = 1'b1;
  end

  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.opcode  = op;
    dec.rd      = i[11:7];
    dec.rs1     = i[19:15];
    dec.rs2     = i[24:20];
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.illegal = ill;
    unique case (1'b1)
      op == OP_ST:
        dec.imm = {{20{i[31]}}, i[31:25], i[11:7]};
      op == OP_LUI || op == OP_AUI:
        dec.imm = {i[31:12], 12'b0};
      op == OP_JAL:
        dec.imm = {{12{i[31]}}, i[19:12], i[20],
                   i[30:21], 1'b0};
      op == OP_BR:
        dec.imm = {{20{i[31]}}, i[7], i[30:25],
                   i[11:8], 1'b0};
      default:
        dec.imm = {{20{i[31]}}, i[31:20]};
    endcase
  end

  // in_ready comes straight from the skid flag, so it is
  // registered and independent of out_ready.
  assign acc  = bus.in_valid & ~skid_v;
  assign free = ~out_v | bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (bus.flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (free) begin
      // skid is older than any new beat; skid full
      // implies in_ready low, so no beat is lost here
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        out_v <= acc;
        if (acc) out_q <= dec;
      end
    end else if (acc) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign bus.in_ready    = ~skid_v;
  assign bus.out_valid   = out_v;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_opcode  = out_q.opcode;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_funct3  = out_q.funct3;
  assign bus.out_funct7  = out_q.funct7;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Testbench for rv32i_decode_stage: decode table plus
// backpressure, flush and async reset sequences.
module tb_rv32i_decode_stage;

  typedef struct {
    logic [31:0] inst;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  localparam int N = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vec_t tbl [N];
  int checks = 0;
  int errors = 0;

  rv32i_decode_stage_if #(.PC_WIDTH(32)) bus ();

  rv32i_decode_stage #(.PC_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] got();
    return {30'd0, bus.out_valid, bus.out_pc,
            bus.out_opcode, bus.out_rd, bus.out_funct3,
            bus.out_rs1, bus.out_rs2, bus.out_funct7,
            bus.out_imm, bus.out_illegal};
  endfunction

  function automatic logic [127:0] want(int k,
                                        logic [31:0] pc);
    vec_t v = tbl[k];
    return {30'd0, 1'b1, pc, v.op, v.rd, v.f3,
            v.rs1, v.rs2, v.f7, v.imm, v.ill};
  endfunction

  task automatic check(string name, logic [127:0] a,
                       logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic drive(int k, logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst  = tbl[k].inst;
    bus.in_pc    = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{32'h00500093, 7'h13, 5'd1, 3'd0, 5'd0, 5'd5, 7'h00, 32'h00000005, 1'b0};
    tbl[1]  = '{32'h12345137, 7'h37, 5'd2, 3'd5, 5'd8, 5'd3, 7'h09, 32'h12345000, 1'b0};
    tbl[2]  = '{32'hFFDFF06F, 7'h6F, 5'd0, 3'd7, 5'd31, 5'd29, 7'h7F, 32'hFFFFFFFC, 1'b0};
    tbl[3]  = '{32'hFE000CE3, 7'h63, 5'd25, 3'd0, 5'd0, 5'd0, 7'h7F, 32'hFFFFFFF8, 1'b0};
    tbl[4]  = '{32'h00512623, 7'h23, 5'd12, 3'd2, 5'd2, 5'd5, 7'h00, 32'h0000000C, 1'b0};
    tbl[5]  = '{32'h00000000, 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b1};
    tbl[6]  = '{32'h40001033, 7'h33, 5'd0, 3'd1, 5'd0, 5'd0, 7'h20, 32'h00000400, 1'b1};
    tbl[7]  = '{32'h00003003, 7'h03, 5'd0, 3'd3, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b1};
    tbl[8]  = '{32'h40005033, 7'h33, 5'd0, 3'd5, 5'd0, 5'd0, 7'h20, 32'h00000400, 1'b0};
    tbl[9]  = '{32'h00004073, 7'h73, 5'd0, 3'd4, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b1};
    tbl[10] = '{32'h00000073, 7'h73, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b0};
    tbl[11] = '{32'h00100073, 7'h73, 5'd0, 3'd0, 5'd0, 5'd1, 7'h00, 32'h00000001, 1'b0};
    tbl[12] = '{32'h00200073, 7'h73, 5'd0, 3'd0, 5'd0, 5'd2, 7'h00, 32'h00000002, 1'b1};
    tbl[13] = '{32'h00002063, 7'h63, 5'd0, 3'd2, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b1};
    tbl[14] = '{32'h00001067, 7'h67, 5'd0, 3'd1, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b1};
    tbl[15] = '{32'h00003023, 7'h23, 5'd0, 3'd3, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b1};
    tbl[16] = '{32'h00002003, 7'h03, 5'd0, 3'd2, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b0};
    tbl[17] = '{32'h40001013, 7'h13, 5'd0, 3'd1, 5'd0, 5'd0, 7'h20, 32'h00000400, 1'b1};
    tbl[18] = '{32'h40005013, 7'h13, 5'd0, 3'd5, 5'd0, 5'd0, 7'h20, 32'h00000400, 1'b0};
    tbl[19] = '{32'h00001017, 7'h17, 5'd0, 3'd1, 5'd0, 5'd0, 7'h00, 32'h00001000, 1'b0};
    tbl[20] = '{32'h00000011, 7'h11, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b1};
    tbl[21] = '{32'h02000033, 7'h33, 5'd0, 3'd0, 5'd0, 5'd0, 7'h01, 32'h00000020, 1'b1};
    tbl[22] = '{32'h0000000F, 7'h0F, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b0};
    tbl[23] = '{32'hFFF00093, 7'h13, 5'd1, 3'd0, 5'd0, 5'd31, 7'h7F, 32'hFFFFFFFF, 1'b0};
    tbl[24] = '{32'hFE112E23, 7'h23, 5'd28, 3'd2, 5'd2, 5'd1, 7'h7F, 32'hFFFFFFFC, 1'b0};
    tbl[25] = '{32'h60005013, 7'h13, 5'd0, 3'd5, 5'd0, 5'd0, 7'h30, 32'h00000600, 1'b1};
    tbl[26] = '{32'h00001063, 7'h63, 5'd0, 3'd1, 5'd0, 5'd0, 7'h00, 32'h00000000, 1'b0};
    tbl[27] = '{32'h00008067, 7'h67, 5'd0, 3'd0, 5'd1, 5'd0, 7'h00, 32'h00000000, 1'b0};

    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) step();
    check("rst_out", got(), 128'd0);
    check("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    rst = 1'b0;
    step();
    check("post_rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    check("post_rst_valid", {127'd0, bus.out_valid}, 128'd0);

    // table stream at one beat per cycle
    drive(0, 32'h100);
    for (int k = 0; k < N; k++) begin
      step();
      check($sformatf("vec%0d", k), got(),
            want(k, 32'h100 + 32'(4 * k)));
      check($sformatf("vec%0d_in_ready", k),
            {127'd0, bus.in_ready}, 128'd1);
      if (k < N - 1) drive(k + 1, 32'h104 + 32'(4 * k));
      else bus.in_valid = 1'b0;
    end
    step();
    check("stream_drained", {127'd0, bus.out_valid}, 128'd0);

    // backpressure: output + skid held for 5 cycles
    bus.out_ready = 1'b0;
    drive(0, 32'h200);
    step();
    check("bp_a_out", got(), want(0, 32'h200));
    check("bp_a_in_ready", {127'd0, bus.in_ready}, 128'd1);
    drive(1, 32'h204);
    step();
    check("bp_skid_in_ready", {127'd0, bus.in_ready}, 128'd0);
    drive(2, 32'h208);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp_hold%0d", c), got(),
            want(0, 32'h200));
      check($sformatf("bp_hold%0d_rdy", c),
            {127'd0, bus.in_ready}, 128'd0);
      step();
    end
    check("bp_hold_last", got(), want(0, 32'h200));
    bus.out_ready = 1'b1;
    step();
    check("bp_b_out", got(), want(1, 32'h204));
    check("bp_b_in_ready", {127'd0, bus.in_ready}, 128'd1);
    step();
    check("bp_c_out", got(), want(2, 32'h208));
    bus.in_valid = 1'b0;
    step();
    check("bp_empty", {127'd0, bus.out_valid}, 128'd0);

    // flush with output and skid full, input valid
    bus.out_ready = 1'b0;
    drive(3, 32'h400);
    step();
    drive(4, 32'h404);
    step();
    check("fl_full_rdy", {127'd0, bus.in_ready}, 128'd0);
    drive(5, 32'h408);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl1_valid", {127'd0, bus.out_valid}, 128'd0);
    check("fl1_in_ready", {127'd0, bus.in_ready}, 128'd1);
    // flush with only output full and in_ready high
    drive(6, 32'h40C);
    step();
    check("fl2_pre", got(), want(6, 32'h40C));
    drive(7, 32'h410);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("fl2_valid", {127'd0, bus.out_valid}, 128'd0);
    check("fl2_in_ready", {127'd0, bus.in_ready}, 128'd1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("fl_no_ghost%0d", c),
            {127'd0, bus.out_valid}, 128'd0);
    end

    // async reset between edges
    bus.out_ready = 1'b0;
    drive(4, 32'h300);
    step();
    check("ar_pre", got(), want(4, 32'h300));
    drive(8, 32'h304);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid_now", {127'd0, bus.out_valid}, 128'd0);
    check("ar_rdy_now", {127'd0, bus.in_ready}, 128'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("ar_no_stale%0d", c),
            {127'd0, bus.out_valid}, 128'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
